rf_sb: RTL and testbench

Parametrised successor to the single-write register file in the datapath core.
- Storage: DEPTH = 2**AW registers of DW bits, two combinational read ports and two write ports. Port W is normal writeback; port L is the late load / multi-cycle result.
- Per-register scoreboard of busy bits, set at issue and cleared by port L, plus a registered busy counter.
- Sits between decode/issue (reads, scoreboard set) and the writeback stage (both write ports), so hazard logic can stall on busy operands.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 85 ++++++++
 rtl/rf_sb.sv | 105 ++++++++++
 tb/tb_rf_sb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the register file and its scoreboard.
//   DefaultDw    : default data width
//   DefaultAw    : default address width
//   DefaultDepth : register count for the default address width
//   R0Idx        : index of the hardwired-zero register
//   depth_of()   : register count for a given address width
package rf_pkg;

  localparam int unsigned DefaultDw    = 32;
  localparam int unsigned DefaultAw    = 5;
  localparam int unsigned R0Idx        = 0;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned DefaultDepth = depth_of(DefaultAw);

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with a registered busy counter.
// A long-latency op marks its destination busy at issue. The late write port
// clears the bit when the result lands.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   set, set_a   : mark set_a busy at the next edge
//   clr, clr_a   : clear busy on clr_a at the next edge (late write port)
//   a1, a2       : read addresses
//   busy1, busy2 : busy status for a1/a2 (combinational)
//   busy_cnt     : registered popcount of the busy vector, 0..DEPTH
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned AW      = DefaultAw,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic [AW-1:0] set_a,
  input  logic          clr,
  input  logic [AW-1:0] clr_a,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   busy_cnt
);

  localparam int unsigned DEPTH = depth_of(AW);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             set_en;
  logic             inc;
  logic             dec;

  always_comb begin
    set_en = set && !(ZERO_R0 && (set_a == AW'(R0Idx)));

    // Only real transitions move the counter. A clear that collides with a
    // set on the same address is overridden, so it is not a 1->0 transition.
    // inc needs the bit at 0 and dec needs it at 1, so the two never hit
    // the same address.
    inc = set_en && !busy_q[set_a];
    dec = clr && busy_q[clr_a] && !(set_en && (set_a == clr_a));

    busy_d = busy_q;
    if (clr) begin
      busy_d[clr_a] = 1'b0;
    end
    // A new issue overlapping an old completion keeps the register busy.
    if (set_en) begin
      busy_d[set_a] = 1'b1;
    end

    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // With bypass enabled, a completing load releases its reader in the same
  // cycle, so the hazard logic does not stall one extra cycle.
  always_comb begin
    busy1 = busy_q[a1] & ~(BYPASS & clr & (clr_a == a1));
    busy2 = busy_q[a2] & ~(BYPASS & clr & (clr_a == a2));
  end

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/rf_sb.sv
// Register file with two combinational read ports, two write ports and a
// per-register busy scoreboard.
// Port W is normal writeback. Port L is the late load / multi-cycle result,
// and it also retires the scoreboard entry of its destination.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   A1, A2            : read addresses
//   RD1, RD2          : read data (combinational)
//   Busy1, Busy2      : scoreboard busy for A1/A2 (combinational)
//   RFWr, A3, WD      : port W write enable / address / data
//   LdWr, LdA, LdWD   : port L write enable / address / data, clears busy[LdA]
//   SbSet, SbA        : mark SbA busy at issue
//   BusyCnt           : registered count of busy registers
module rf_sb
  import rf_pkg::*;
#(
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned AW      = DefaultAw,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          Busy1,
  output logic          Busy2,
  input  logic          RFWr,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD,
  input  logic          LdWr,
  input  logic [AW-1:0] LdA,
  input  logic [DW-1:0] LdWD,
  input  logic          SbSet,
  input  logic [AW-1:0] SbA,
  output logic [AW:0]   BusyCnt
);

  localparam int unsigned DEPTH = depth_of(AW);

  logic [DW-1:0] rf_q [DEPTH];
  logic          w_en;
  logic          l_en;

  always_comb begin
    w_en = RFWr && !(ZERO_R0 && (A3 == AW'(R0Idx)));
    l_en = LdWr && !(ZERO_R0 && (LdA == AW'(R0Idx)));
  end

  // Port L is written last, so it wins when both ports target one address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q <= '{default: '0};
    end else begin
      if (w_en) begin
        rf_q[A3] <= WD;
      end
      if (l_en) begin
        rf_q[LdA] <= LdWD;
      end
    end
  end

  // Read mux. Forwarding uses the same priority as the write conflict rule,
  // so a bypassed read always matches what the register holds after the edge.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
    logic [DW-1:0] val;
    if (ZERO_R0 && (a == AW'(R0Idx))) begin
      val = '0;
    end else if (BYPASS && LdWr && (LdA == a)) begin
      val = LdWD;
    end else if (BYPASS && RFWr && (A3 == a)) begin
      val = WD;
    end else begin
      val = rf_q[a];
    end
    return val;
  endfunction

  always_comb begin
    RD1 = read_port(A1);
    RD2 = read_port(A2);
  end

  rf_scoreboard #(
    .AW      (AW),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set      (SbSet),
    .set_a    (SbA),
    .clr      (LdWr),
    .clr_a    (LdA),
    .a1       (A1),
    .a2       (A2),
    .busy1    (Busy1),
    .busy2    (Busy2),
    .busy_cnt (BusyCnt)
  );

endmodule

// File: tb/tb_rf_sb.sv
// Bench for rf_sb: one bypassing and one non-bypassing instance driven by the
// same stimulus, checked every cycle against an architectural model, plus
// hand-computed expectations along the directed sequence.
module tb_rf_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] A1, A2, A3, LdA, SbA;
  logic [DW-1:0] WD, LdWD;
  logic          RFWr, LdWr, SbSet;

  logic [DW-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic          b_bz1, b_bz2, n_bz1, n_bz2;
  logic [AW:0]   b_cnt, n_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Architectural model: register contents and busy flags after each edge.
  logic [DW-1:0] m_rf   [N];
  bit            m_busy [N];

  always #5 clk = ~clk;

  rf_sb #(.DW(DW), .AW(AW), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(b_rd1), .RD2(b_rd2),
    .Busy1(b_bz1), .Busy2(b_bz2), .RFWr(RFWr), .A3(A3), .WD(WD),
    .LdWr(LdWr), .LdA(LdA), .LdWD(LdWD), .SbSet(SbSet), .SbA(SbA),
    .BusyCnt(b_cnt)
  );

  rf_sb #(.DW(DW), .AW(AW), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(n_rd1), .RD2(n_rd2),
    .Busy1(n_bz1), .Busy2(n_bz2), .RFWr(RFWr), .A3(A3), .WD(WD),
    .LdWr(LdWr), .LdA(LdA), .LdWD(LdWD), .SbSet(SbSet), .SbA(SbA),
    .BusyCnt(n_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What a reader must see this cycle, given the model state and the
  // in-flight writes.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && LdWr && LdA == a) return LdWD;
    if (byp && RFWr && A3 == a) return WD;
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    return m_busy[a] && !(byp && LdWr && LdA == a);
  endfunction

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_rf[i]   = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (RFWr && A3 != 0) m_rf[A3] = WD;
      if (LdWr && LdA != 0) m_rf[LdA] = LdWD;
      if (LdWr) m_busy[LdA] = 1'b0;
      if (SbSet && SbA != 0) m_busy[SbA] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("b_rd1", b_rd1, exp_rd(A1, 1'b1));
      check("b_rd2", b_rd2, exp_rd(A2, 1'b1));
      check("b_busy1", b_bz1, exp_busy(A1, 1'b1));
      check("b_busy2", b_bz2, exp_busy(A2, 1'b1));
      check("b_cnt", b_cnt, popcount());
      check("n_rd1", n_rd1, exp_rd(A1, 1'b0));
      check("n_rd2", n_rd2, exp_rd(A2, 1'b0));
      check("n_busy1", n_bz1, exp_busy(A1, 1'b0));
      check("n_busy2", n_bz2, exp_busy(A2, 1'b0));
      check("n_cnt", n_cnt, popcount());
    end
  end

  // Advance past the next edge; inputs are then driven 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RFWr = 0; LdWr = 0; SbSet = 0;
  endtask

  initial begin
    rst = 1; A1 = 0; A2 = 0; A3 = 0; LdA = 0; SbA = 0;
    WD = 0; LdWD = 0; RFWr = 0; LdWr = 0; SbSet = 0;
    cyc();
    cyc();
    cmp_en = 1'b1;
    rst = 0;

    // Reset state across all addresses.
    for (int a = 0; a < N; a++) begin
      A1 = AW'(a); A2 = AW'(N - 1 - a);
      #2;
      check("rst_rd1", b_rd1, 0);
      check("rst_rd2", n_rd2, 0);
      check("rst_busy", b_bz1 | n_bz2, 0);
      check("rst_cnt", b_cnt, 0);
      cyc();
    end

    // Write r5, then reset clears it.
    RFWr = 1; A3 = 5; WD = 32'hDEADBEEF; A1 = 5;
    #2;
    check("r5_byp", b_rd1, 32'hDEADBEEF);
    check("r5_nobyp", n_rd1, 0);
    cyc();
    idle(); rst = 1;
    #2;
    check("r5_stored", n_rd1, 32'hDEADBEEF);
    cyc();
    rst = 0;
    #2;
    check("r5_after_rst_b", b_rd1, 0);
    check("r5_after_rst_n", n_rd1, 0);
    cyc();

    // Port conflict on r7: port L wins.
    RFWr = 1; A3 = 7; WD = 32'h11; LdWr = 1; LdA = 7; LdWD = 32'h22; A1 = 7;
    #2;
    check("r7_fwd_b", b_rd1, 32'h22);
    check("r7_old_n", n_rd1, 0);
    cyc();
    idle();
    #2;
    check("r7_after_b", b_rd1, 32'h22);
    check("r7_after_n", n_rd1, 32'h22);
    cyc();

    // Non-bypass visibility on r3.
    RFWr = 1; A3 = 3; WD = 32'h55; A1 = 3;
    #2;
    check("r3_old_n", n_rd1, 0);
    check("r3_fwd_b", b_rd1, 32'h55);
    cyc();
    idle();
    #2;
    check("r3_new_n", n_rd1, 32'h55);
    cyc();

    // r0 is hardwired: writes via both ports and a scoreboard set are ignored.
    RFWr = 1; A3 = 0; WD = '1; A1 = 0; A2 = 0;
    #2;
    check("r0_w_fwd", b_rd1, 0);
    cyc();
    idle(); LdWr = 1; LdA = 0; LdWD = '1;
    #2;
    check("r0_l_fwd", b_rd2, 0);
    cyc();
    idle(); SbSet = 1; SbA = 0;
    cyc();
    idle();
    #2;
    check("r0_rd", n_rd1, 0);
    check("r0_busy", b_bz1 | n_bz1, 0);
    check("r0_cnt", b_cnt, 0);
    cyc();

    // Scoreboard: set 4, 9, 4.
    SbSet = 1; SbA = 4; cyc();
    #2; check("cnt_1", b_cnt, 1);
    SbA = 9; cyc();
    #2; check("cnt_2", b_cnt, 2);
    SbA = 4; cyc();
    idle(); A1 = 4; A2 = 9;
    #2;
    check("cnt_2b", b_cnt, 2);
    check("busy4", n_bz1, 1);
    // Completion on r4 releases the bypassing reader in the same cycle.
    LdWr = 1; LdA = 4; LdWD = 32'h44;
    #1;
    check("busy4_fwd_b", b_bz1, 0);
    check("busy4_hold_n", n_bz1, 1);
    cyc();
    idle();
    #2; check("cnt_after_clr4", n_cnt, 1);
    // Overlapping issue and completion on r9.
    SbSet = 1; SbA = 9; LdWr = 1; LdA = 9; LdWD = 32'h99;
    cyc();
    idle();
    #2;
    check("busy9_stays", n_bz2, 1);
    check("cnt_overlap", b_cnt, 1);
    LdWr = 1; LdA = 9;
    cyc();
    idle();
    #2; check("cnt_zero", b_cnt, 0);

    // Fill the whole scoreboard, then drain it.
    for (int a = 1; a < N; a++) begin
      SbSet = 1; SbA = AW'(a); cyc();
    end
    idle();
    #2; check("cnt_full", b_cnt, 31);
    for (int a = 1; a < N; a++) begin
      LdWr = 1; LdA = AW'(a); LdWD = DW'(a * 3); cyc();
    end
    idle();
    #2; check("cnt_drained", n_cnt, 0);
    LdWr = 1; LdA = 5; LdWD = 32'h5;
    cyc();
    idle();
    #2; check("cnt_no_underflow", b_cnt, 0);
    cyc();

    // Mixed traffic on a small address window to force collisions.
    for (int i = 0; i < 300; i++) begin
      A1 = AW'($urandom_range(0, 7)); A2 = AW'($urandom_range(0, 7));
      RFWr = 1'($urandom); A3 = AW'($urandom_range(0, 7)); WD = $urandom;
      LdWr = 1'($urandom); LdA = AW'($urandom_range(0, 7)); LdWD = $urandom;
      SbSet = 1'($urandom); SbA = AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 0; idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
